// File: rtl/ifu.sv
// Instruction fetch unit: assembles 24-bit big-endian instructions from a
// byte-wide synchronous-read program memory and hands them to the ECU.
module ifu #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [23:0] raw,
  output logic [15:0] pc_out,
  output logic        raw_valid,
  input  logic        raw_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_A0 = 3'd0;
  localparam logic [2:0] S_A1 = 3'd1;
  localparam logic [2:0] S_A2 = 3'd2;
  localparam logic [2:0] S_C  = 3'd3;
  localparam logic [2:0] S_V  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [23:0] raw_q, raw_d;

  // Handshake: an instruction transfers on any cycle where raw_valid and
  // raw_ready are both high; raw/pc_out hold while raw_valid && !raw_ready.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    raw_d    = raw_q;
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_A0: begin
        if (fetch_en) begin
          mem_rd  = 1'b1;
          state_d = S_A1;
        end
      end
      S_A1: begin
        mem_rd         = 1'b1;
        mem_addr       = pc_q + 16'd1;
        raw_d[23:16]   = mem_data;
        state_d        = S_A2;
      end
      S_A2: begin
        mem_rd         = 1'b1;
        mem_addr       = pc_q + 16'd2;
        raw_d[15:8]    = mem_data;
        state_d        = S_C;
      end
      S_C: begin
        raw_d[7:0]     = mem_data;
        state_d        = S_V;
      end
      S_V: begin
        if (raw_ready) begin
          pc_d    = pc_q + 16'd3;
          state_d = S_A0;
        end
      end
      default: state_d = S_A0;
    endcase
    // A jump wins over fetch progress and over a simultaneous accept.
    if (redirect) begin
      pc_d    = redirect_addr;
      state_d = S_A0;
      raw_d   = raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A0;
      pc_q    <= RESET_PC;
      raw_q   <= 24'h000000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      raw_q   <= raw_d;
    end
  end

  assign raw       = raw_q;
  assign pc_out    = pc_q;
  assign raw_valid = (state_q == S_V);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: basic fetch, stall, redirects, wrap-around,
// fetch_en gating and mid-fetch reset against a behavioural program memory.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [23:0] raw;
  logic [15:0] pc_out;
  logic        raw_valid;
  logic        raw_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  ifu #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .raw(raw), .pc_out(pc_out), .raw_valid(raw_valid), .raw_ready(raw_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read program memory
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h56;
    mem[16'h0003] = 8'h9A; mem[16'h0004] = 8'hBC; mem[16'h0005] = 8'hDE;
    mem[16'h0006] = 8'h01; mem[16'h0007] = 8'h02; mem[16'h0008] = 8'h03;
    mem[16'h0040] = 8'h44; mem[16'h0041] = 8'h55; mem[16'h0042] = 8'h66;
    mem[16'h0100] = 8'hC0; mem[16'h0101] = 8'hFF; mem[16'h0102] = 8'hEE;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
    mem_data = 8'h00;

    rst = 1'b1; fetch_en = 1'b1; raw_ready = 1'b1;
    redirect = 1'b0; redirect_addr = 16'h0000;
    step(); step();
    check("rst_raw_valid", {31'd0, raw_valid}, 32'd0);
    check("rst_raw", {8'd0, raw}, 32'h0);
    check("rst_pc_out", {16'd0, pc_out}, 32'h0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("rst_state", {29'd0, state_dbg}, 32'd0);

    // basic fetch: cycle 0 is the A0 issue
    rst = 1'b0;
    check("f0_addr", {16'd0, mem_addr}, 32'h0);
    step(); check("f1_addr", {16'd0, mem_addr}, 32'h1);
    check("f1_rd", {31'd0, mem_rd}, 32'd1);
    check("f1_valid", {31'd0, raw_valid}, 32'd0);
    step(); check("f2_addr", {16'd0, mem_addr}, 32'h2);
    step(); check("f3_rd", {31'd0, mem_rd}, 32'd0);
    check("f3_valid", {31'd0, raw_valid}, 32'd0);
    step(); check("f4_valid", {31'd0, raw_valid}, 32'd1);
    check("f4_raw", {8'd0, raw}, 32'h123456);
    check("f4_pc", {16'd0, pc_out}, 32'h0);
    check("f4_state", {29'd0, state_dbg}, 32'd4);

    // second fetch at pc+3, then stall in V
    step(); check("g0_addr", {16'd0, mem_addr}, 32'h3);
    check("g0_valid", {31'd0, raw_valid}, 32'd0);
    raw_ready = 1'b0;
    step(); check("g1_addr", {16'd0, mem_addr}, 32'h4);
    step(); check("g2_addr", {16'd0, mem_addr}, 32'h5);
    step(); check("g3_rd", {31'd0, mem_rd}, 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", {31'd0, raw_valid}, 32'd1);
      check("stall_raw", {8'd0, raw}, 32'h9ABCDE);
      check("stall_pc", {16'd0, pc_out}, 32'h3);
      check("stall_rd", {31'd0, mem_rd}, 32'd0);
      step();
    end
    raw_ready = 1'b1;
    step(); check("acc_addr", {16'd0, mem_addr}, 32'h6);
    check("acc_rd", {31'd0, mem_rd}, 32'd1);

    // redirect while in A2
    step(); step();
    check("a2_state", {29'd0, state_dbg}, 32'd2);
    redirect = 1'b1; redirect_addr = 16'h0100;
    step(); redirect = 1'b0;
    check("rd_addr", {16'd0, mem_addr}, 32'h0100);
    check("rd_rd", {31'd0, mem_rd}, 32'd1);
    check("rd_valid0", {31'd0, raw_valid}, 32'd0);
    step(); check("rd_valid1", {31'd0, raw_valid}, 32'd0);
    step(); check("rd_valid2", {31'd0, raw_valid}, 32'd0);
    step(); check("rd_valid3", {31'd0, raw_valid}, 32'd0);
    step(); check("rd_valid4", {31'd0, raw_valid}, 32'd1);
    check("rd_raw", {8'd0, raw}, 32'hC0FFEE);
    check("rd_pc", {16'd0, pc_out}, 32'h0100);

    // redirect together with handshake
    redirect = 1'b1; redirect_addr = 16'h0040;
    step(); redirect = 1'b0;
    check("hs_addr", {16'd0, mem_addr}, 32'h0040);
    check("hs_valid", {31'd0, raw_valid}, 32'd0);
    step(); step(); step(); step();
    check("hs_v_valid", {31'd0, raw_valid}, 32'd1);
    check("hs_v_raw", {8'd0, raw}, 32'h445566);
    check("hs_v_pc", {16'd0, pc_out}, 32'h0040);

    // wrap-around: jump to 0xFFFE via redirect+handshake
    redirect = 1'b1; redirect_addr = 16'hFFFE;
    step(); redirect = 1'b0;
    check("wr_a0", {16'd0, mem_addr}, 32'hFFFE);
    step(); check("wr_a1", {16'd0, mem_addr}, 32'hFFFF);
    step(); check("wr_a2", {16'd0, mem_addr}, 32'h0000);
    step(); step();
    check("wr_raw", {8'd0, raw}, 32'hAABB12);
    check("wr_pc", {16'd0, pc_out}, 32'hFFFE);

    // accept with fetch_en low: idle in A0 at pc 0x0001
    fetch_en = 1'b0;
    step();
    check("wr_acc_pc", {16'd0, pc_out}, 32'h0001);
    for (int i = 0; i < 3; i++) begin
      check("idle_rd", {31'd0, mem_rd}, 32'd0);
      check("idle_state", {29'd0, state_dbg}, 32'd0);
      step();
    end
    fetch_en = 1'b1;
    #1 check("en_addr", {16'd0, mem_addr}, 32'h0001);
    check("en_rd", {31'd0, mem_rd}, 32'd1);

    // reset while in A1
    step();
    check("a1_state", {29'd0, state_dbg}, 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("mr_valid", {31'd0, raw_valid}, 32'd0);
    check("mr_raw", {8'd0, raw}, 32'h0);
    check("mr_addr", {16'd0, mem_addr}, 32'h0);
    check("mr_state", {29'd0, state_dbg}, 32'd0);
    fetch_en = 1'b0;
    #1 check("mr_rd_off", {31'd0, mem_rd}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit sitting directly upstream of the execution control unit (ECU). It fetches 24-bit instructions as three consecutive bytes from a byte-wide, synchronous-read program memory, presents each assembled instruction with its address to the ECU over a valid/ready handshake, and redirects on jumps signalled by the ECU.

## Interface
- `RESET_PC`, default `16'h0000`: program counter value loaded on reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `fetch_en`  in  1  allows a new fetch to start; has no effect on a fetch already in progress.
- `mem_addr`  out  16  byte address to program memory.
- `mem_rd`  out  1  read strobe; the memory returns `mem_data` on the next cycle.
- `mem_data`  in  8  read data, valid exactly one cycle after `mem_rd`.
- `raw`  out  24  assembled instruction, connected to ECU `raw`.
- `pc_out`  out  16  address of the first byte of `raw`, connected to ECU `ai`.
- `raw_valid`  out  1  `raw` and `pc_out` are valid.
- `raw_ready`  in  1  the ECU accepts the instruction this cycle.
- `redirect`  in  1  jump taken; discard any in-flight fetch.
- `redirect_addr`  in  16  jump target, connected to ECU `ao`.

## Operation
- State: `pc[15:0]`, byte buffer, and a state register with states A0, A1, A2, C, V.
- **A0:** if `fetch_en` is high: `mem_rd`=1, `mem_addr`=`pc`, go to A1. Otherwise `mem_rd`=0 and stay in A0.
- **A1:** `mem_rd`=1, `mem_addr`=`pc+1`; capture `mem_data` into `raw[23:16]`; go to A2.
- **A2:** `mem_rd`=1, `mem_addr`=`pc+2`; capture `mem_data` into `raw[15:8]`; go to C.
- **C:** `mem_rd`=0; capture `mem_data` into `raw[7:0]`; go to V.
- **V:** `raw_valid`=1 and `pc_out`=`pc`.
  - `raw` and `pc_out` hold stable while `raw_ready`=0.
  - On `raw_ready`=1: `pc` ← `pc+3`, go to A0.
- Byte order is big-endian: the byte at `pc` lands in `raw[23:16]`.
- Address arithmetic is 16-bit modulo 2^16; `pc+1`, `pc+2` and `pc+3` wrap silently.
- `mem_addr` is don't-care when `mem_rd`=0; drive `pc`.
- **Redirect**, taking priority over everything except `rst`, in any state:
  - `pc` ← `redirect_addr`, state ← A0.
  - Partial bytes are discarded, and the data returned for an outstanding read is ignored.
  - `raw_valid` is 0 on the next cycle.
- **Redirect together with a handshake** (V, `raw_ready`=1, `redirect`=1): the instruction counts as consumed, and `pc` ← `redirect_addr` (not `pc+3`).
- **Reset:** `pc` ← `RESET_PC`, state ← A0, `raw` ← 0, `raw_valid` ← 0. Reset overrides `redirect` and the handshake in the same cycle.

## Timing
- Reset values:
  - `raw_valid`=0, `raw`=24'h000000, `pc_out`=`RESET_PC`.
  - `mem_addr`=`RESET_PC`.
  - `mem_rd`=`fetch_en`, since A0 is active from the first cycle after reset.
- `raw_valid` is registered (state==V). `mem_rd` and `mem_addr` are combinational from state, `pc` and `fetch_en`.
- Latency: A0 issue in cycle n → `raw_valid`=1 in cycle n+4.
- Back-to-back instructions with `raw_ready` held at 1 take one instruction every 5 cycles.
- Exactly three `mem_rd` pulses per completed fetch, on consecutive cycles.
- A redirect in cycle n → A0 issues `redirect_addr` in cycle n+1 (provided `fetch_en`=1).
- `raw_valid` never rises sooner than 4 cycles after a redirect.
- Mid-fetch reset: no `mem_rd` is issued in the cycle after `rst` except the A0 issue at `RESET_PC`, and only if `fetch_en`=1.

## Test plan
- **Basic fetch.** Setup: reset with `RESET_PC`=0; memory holds 0x12, 0x34, 0x56 at 0..2; `fetch_en`=1, `raw_ready`=1. Required response:
  - `raw_valid` on cycle 4 after reset release with `raw`=0x123456 and `pc_out`=0.
  - Next fetch `mem_addr` sequence 3, 4, 5.
- **Stall.** Setup: hold `raw_ready`=0 for 6 cycles in V. Required response:
  - `raw`, `pc_out` and `raw_valid` stay constant, with no `mem_rd`.
  - On `raw_ready`=1, next A0 at `pc+3`.
- **Wrap-around.** Setup: `pc`=0xFFFE. Required response:
  - Addresses 0xFFFE, 0xFFFF, 0x0000.
  - After accept, `pc`=0x0001.
- **Redirect mid-fetch.** Setup: assert `redirect` with `redirect_addr`=0x0100 while in A2. Required response:
  - No `raw_valid` for the aborted fetch.
  - Next cycle `mem_addr`=0x0100, and the following `raw` equals the bytes at 0x0100..0x0102.
- **Redirect with handshake in V.** Setup: `redirect_addr`=0x0040. Required response:
  - The instruction is consumed once.
  - Next A0 at 0x0040, not `pc+3`.
- **fetch_en and reset.** Setup: `fetch_en`=0 after accept. Required response:
  - Stays in A0 with `mem_rd`=0.
  - `rst` asserted in A1 → `raw_valid`=0; `mem_addr`=`RESET_PC` afterwards.
